// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / meter pair: default widths and
// the meter state encoding.
package pwm_pkg;

    localparam int PWM_W = 32;
    localparam int PWM_R = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } meter_state_t;

    // Duty code that represents 100 % at resolution r.
    function automatic int unsigned duty_full(input int unsigned r);
        return 32'd1 << r;
    endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Iterative restoring divider producing an R+1-bit duty code, one quotient bit
// per cycle, MSB first.
module pwm_duty_div
    import pwm_pkg::*;
#(
    parameter int W = PWM_W,
    parameter int R = PWM_R
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         abort,
    input  logic [W-1:0] num,
    input  logic [W-1:0] den,
    output logic         busy,
    output logic         done,
    output logic [R:0]   q
);

    localparam int IW = $clog2(R + 2);

    logic [W:0]    rem;
    logic [W:0]    cand;
    logic [W:0]    diff;
    logic [W-1:0]  den_r;
    logic [IW-1:0] idx;
    logic          first;
    logic          ge;

    // The first step compares the unshifted numerator; that produces the
    // integer bit q[R], which is only ever set at exactly 100 % duty.
    always_comb begin
        cand = first ? rem : {rem[W-1:0], 1'b0};
        ge   = (cand >= {1'b0, den_r});
        diff = cand - {1'b0, den_r};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem   <= '0;
            den_r <= '0;
            idx   <= '0;
            first <= 1'b0;
            q     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem   <= {1'b0, num};
                den_r <= den;
                idx   <= IW'(R);
                first <= 1'b1;
                q     <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                if (ge) begin
                    rem    <= diff;
                    q[idx] <= 1'b1;
                end else begin
                    rem <= cand;
                end
                first <= 1'b0;
                if (idx == '0) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    idx <= idx - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_meter.sv
// PWM input meter: synchronizes pwm_in, measures period and high time in clk
// cycles, converts to a duty code and reports static levels by timeout.
module pwm_meter
    import pwm_pkg::*;
#(
    parameter int W = PWM_W,
    parameter int R = PWM_R
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         pwm_in,
    input  logic [W-1:0] timeout,
    input  logic         clr_ovr,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic [R:0]   duty,
    output logic         valid,
    output logic         overrun,
    output logic         level
);

    localparam logic [R:0] DUTY_FULL = (R+1)'(duty_full(R));

    meter_state_t state, state_next;

    logic         s1, s2, s3;
    logic         rise, fall, edge_seen;
    logic [W-1:0] cnt, hi_cap;
    logic [W-1:0] div_hi, div_per;
    logic         tmo_fire;
    logic         cnt_load, cap_hi, div_start, drop, div_abort;
    logic         div_busy, div_done;
    logic [R:0]   div_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
    assign level = s2;

    // Only an edge the current state acts on suppresses the timeout; a fall
    // seen while arming must not stall the static-level report.
    assign edge_seen = ((state == ST_ARM || state == ST_LOW) && rise) ||
                       ((state == ST_HIGH) && fall);
    assign tmo_fire  = en && (state != ST_IDLE) && (cnt == timeout) && !edge_seen;
    assign div_abort = ~en | tmo_fire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_load   = 1'b0;
        cap_hi     = 1'b0;
        div_start  = 1'b0;
        drop       = 1'b0;
        if (!en) begin
            state_next = ST_IDLE;
        end else if (tmo_fire) begin
            state_next = ST_ARM;
            cnt_load   = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_ARM;
                    cnt_load   = 1'b1;
                end
                ST_ARM: begin
                    if (rise) begin
                        state_next = ST_HIGH;
                        cnt_load   = 1'b1;
                    end
                end
                ST_HIGH: begin
                    if (fall) begin
                        state_next = ST_LOW;
                        cap_hi     = 1'b1;
                    end
                end
                ST_LOW: begin
                    if (rise) begin
                        state_next = ST_HIGH;
                        cnt_load   = 1'b1;
                        if (div_busy) drop = 1'b1;
                        else          div_start = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // cnt doubles as the period capture: at the closing rise it holds H+L.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            hi_cap  <= '0;
            div_hi  <= '0;
            div_per <= '0;
        end else begin
            if (cnt_load)               cnt <= W'(1);
            else if (state != ST_IDLE)  cnt <= cnt + 1'b1;
            if (cap_hi) hi_cap <= cnt;
            if (div_start) begin
                div_hi  <= hi_cap;
                div_per <= cnt;
            end
        end
    end

    pwm_duty_div #(
        .W (W),
        .R (R)
    ) u_div (
        .clk   (clk),
        .reset (reset),
        .start (div_start),
        .abort (div_abort),
        .num   (hi_cap),
        .den   (cnt),
        .busy  (div_busy),
        .done  (div_done),
        .q     (div_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= 1'b0;
            period    <= '0;
            high_time <= '0;
            duty      <= '0;
            overrun   <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (tmo_fire) begin
                valid     <= 1'b1;
                period    <= '0;
                high_time <= s2 ? timeout : '0;
                duty      <= s2 ? DUTY_FULL : '0;
            end else if (div_done && en) begin
                valid     <= 1'b1;
                period    <= div_per;
                high_time <= div_hi;
                duty      <= div_q;
            end
            if (drop)         overrun <= 1'b1;
            else if (clr_ovr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter: PWM patterns, static timeouts, overrun,
// reset and enable interruptions.
module tb_pwm_meter;

    localparam int W = 32;
    localparam int R = 10;

    logic         clk, reset, en, pwm_in, clr_ovr;
    logic [W-1:0] timeout;
    logic [W-1:0] period, high_time;
    logic [R:0]   duty;
    logic         valid, overrun, level;

    int passes = 0;
    int total  = 0;
    int cyc    = 0;
    int hi_len = 25;
    int lo_len = 75;
    int ph     = 0;
    bit static_mode = 1'b1;
    bit static_lvl  = 1'b0;

    pwm_meter #(.W(W), .R(R)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .pwm_in    (pwm_in),
        .timeout   (timeout),
        .clr_ovr   (clr_ovr),
        .period    (period),
        .high_time (high_time),
        .duty      (duty),
        .valid     (valid),
        .overrun   (overrun),
        .level     (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Waveform source, updated on the falling edge.
    initial begin
        pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            if (static_mode) begin
                pwm_in = static_lvl;
            end else begin
                pwm_in = (ph < hi_len);
                ph = ph + 1;
                if (ph >= hi_len + lo_len) ph = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < max_cyc && !ok; i++) begin
            @(posedge clk);
            #1;
            if (valid) ok = 1'b1;
        end
        if (!ok) check({tag, "_wait"}, 64'(ok), 64'd1);
    endtask

    task automatic check_report(input string tag, input int p, input int h, input int d);
        check({tag, "_period"}, 64'(period), 64'(p));
        check({tag, "_high"},   64'(high_time), 64'(h));
        check({tag, "_duty"},   64'(duty), 64'(d));
    endtask

    initial begin
        int  t0, t1, nv;
        bit  ok;
        reset   = 1'b1;
        en      = 1'b0;
        clr_ovr = 1'b0;
        timeout = 32'd5000;
        repeat (5) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid), 64'd0);
        check_report("rst", 0, 0, 0);
        check("rst_overrun", 64'(overrun), 64'd0);
        check("rst_level", 64'(level), 64'd0);

        // 25/75 waveform
        hi_len = 25; lo_len = 75; ph = 0; static_mode = 1'b0;
        reset = 1'b0;
        en    = 1'b1;
        wait_valid("p25_skip", 400);
        wait_valid("p25_a", 400);
        t0 = cyc;
        check_report("p25_a", 100, 25, 256);
        check("p25_a_ovr", 64'(overrun), 64'd0);
        wait_valid("p25_b", 400);
        t1 = cyc;
        check("p25_interval", 64'(t1 - t0), 64'd100);
        check_report("p25_b", 100, 25, 256);

        // reset shortly after a divide launch
        wait_valid("rst2_sync", 400);
        repeat (93) @(posedge clk);
        #1;
        reset = 1'b1;
        nv = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("rst2_no_valid", 64'(nv), 64'd0);
        check_report("rst2", 0, 0, 0);
        check("rst2_overrun", 64'(overrun), 64'd0);
        check("rst2_level", 64'(level), 64'd0);
        reset = 1'b0;
        t0 = cyc;
        wait_valid("rst2_after", 400);
        check("rst2_partial_skipped", 64'((cyc - t0) > 100), 64'd1);
        check_report("rst2_after", 100, 25, 256);

        // disable mid-HIGH, outputs hold, then re-arm
        wait_valid("en_sync", 400);
        repeat (3) @(posedge clk);
        #1;
        en = 1'b0;
        nv = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (valid) nv++;
        end
        check("en_no_valid", 64'(nv), 64'd0);
        check_report("en_hold", 100, 25, 256);
        en = 1'b1;
        wait_valid("en_rearm", 400);
        check_report("en_rearm", 100, 25, 256);

        // narrow pulses
        hi_len = 1; lo_len = 999;
        wait_valid("n1_skip0", 3000);
        wait_valid("n1_skip1", 3000);
        wait_valid("n1", 3000);
        check_report("n1", 1000, 1, 1);
        hi_len = 999; lo_len = 1;
        wait_valid("n999_skip0", 3000);
        wait_valid("n999_skip1", 3000);
        wait_valid("n999", 3000);
        check_report("n999", 1000, 999, 1022);

        // static high, then static low
        static_lvl = 1'b1; static_mode = 1'b1; timeout = 32'd500;
        wait_valid("st1_a", 1000);
        t0 = cyc;
        check_report("st1_a", 0, 500, 1024);
        check("st1_level", 64'(level), 64'd1);
        wait_valid("st1_b", 1000);
        t1 = cyc;
        check("st1_interval", 64'(t1 - t0), 64'd500);
        static_lvl = 1'b0;
        wait_valid("st0_a", 1000);
        t0 = cyc;
        check_report("st0_a", 0, 0, 0);
        check("st0_level", 64'(level), 64'd0);
        wait_valid("st0_b", 1000);
        t1 = cyc;
        check("st0_interval", 64'(t1 - t0), 64'd500);

        // 2/2 waveform overruns the divider
        hi_len = 2; lo_len = 2; ph = 0; static_mode = 1'b0;
        wait_valid("ovr_skip", 200);
        wait_valid("ovr", 200);
        check_report("ovr", 4, 2, 512);
        check("ovr_set", 64'(overrun), 64'd1);
        clr_ovr = 1'b1;
        @(posedge clk);
        #1;
        clr_ovr = 1'b0;
        check("ovr_cleared", 64'(overrun), 64'd0);
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (overrun) ok = 1'b1;
        end
        check("ovr_reset_by_drop", 64'(ok), 64'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/pwm_meter.md
Name: pwm_meter

Overview:
- Receive-side counterpart of the MMIO PWM generator core; sits in the same MMIO subsystem.
- Samples an external PWM waveform and measures its period and high time in clk cycles.
- Converts the measurement to an R+1-bit duty code on the same scale the generator accepts, where 2^R means 100 %.
- Detects static (0 % / 100 %) inputs by timeout, and flags samples dropped while the divider is busy.

Parameters:
W, 32, width of the period/high-time counters and the timeout port
R, 10, duty resolution; duty output is R+1 bits, range 0..2^R

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
en  input  1  measurement enable; 0 forces IDLE
pwm_in  input  1  asynchronous PWM input
timeout  input  W  cycles without an edge before a static level is reported; must be >= 2
clr_ovr  input  1  one-cycle pulse; clears overrun
period  output  W  last measured period in clk cycles; 0 after a timeout report
high_time  output  W  last measured high time in clk cycles
duty  output  R+1  floor(high_time * 2^R / period)
valid  output  1  one-cycle pulse; period, high_time and duty are updated in the same cycle
overrun  output  1  sticky flag: a completed period was dropped because the divider was busy
level  output  1  current synchronized input level

Behaviour:
- Reset (synchronous, active-high; aborts any operation at the next edge):
  - all outputs 0; state IDLE; synchronizer flops 0; divider idle.
- Input path: 2-FF synchronizer, then one delay flop. rise = s2 & ~s3, fall = ~s2 & s3. Edge detection is 3 edges after a pwm_in change. level = s2.
- FSM states: IDLE, ARM, HIGH, LOW.
- Counter cnt (W bits):
  - loaded with 1 on entering ARM or on a rise;
  - otherwise increments every cycle in ARM, HIGH and LOW.
- Transitions:
  - IDLE: en=1 -> ARM, cnt<=1.
  - ARM: rise -> HIGH, cnt<=1. The first partial period is never reported.
  - HIGH: fall -> LOW, hi_cap<=cnt.
  - LOW: rise -> HIGH, per_cap<=cnt, cnt<=1. If the divider is idle, launch the divide with (hi_cap, per_cap). If it is busy, drop the sample and set overrun.
  - Any state, en=0 -> IDLE next edge. Divider aborts with no valid; outputs hold their last values.
- Count definitions: for a waveform high H cycles and low L cycles, per_cap = H+L and hi_cap = H.
- Timeout:
  - In ARM, HIGH or LOW, when cnt == timeout and no edge occurs that cycle: next state ARM, cnt<=1, divider aborted.
  - Next cycle: valid=1, period=0, high_time = level ? timeout : 0, duty = level ? 2^R : 0.
  - A persistently static input therefore reports every timeout cycles.
  - An edge arriving in the same cycle as the timeout match takes priority; no timeout fires.
- Divider (restoring, one quotient bit per cycle, MSB first, R+1 cycles):
  - Init: rem = hi_cap (W+1 bits).
  - Bit R: if rem >= per, set q[R] and rem -= per.
  - Bits R-1..0: rem <<= 1; if rem >= per, set q[i] and rem -= per.
  - Because hi_cap <= per_cap, the quotient always fits in R+1 bits; per_cap >= 2 by construction.
- Latency: valid rises exactly R+2 edges after the edge that captured per_cap. period, high_time and duty register together with valid.
- Simultaneous events:
  - Timeout vs. divider completion in the same cycle: timeout wins and the divide result is discarded.
  - clr_ovr in the same cycle as a new overrun: overrun stays 1.
- overrun stays set until clr_ovr or reset.

Decomposition:
- Package pwm_pkg:
  - state enum (IDLE, ARM, HIGH, LOW);
  - default W and R constants, shared with the generator core.
- Sub-module pwm_duty_div, parameters W and R:
  - inputs: start, num[W-1:0], den[W-1:0], abort;
  - outputs: busy, done (one-cycle pulse), q[R:0].
  - Holds the iterative restoring divider.
- The top level holds the synchronizer, FSM, counters, timeout and output registers.

Test Plan:
1. R=10, timeout=5000, en=1, PWM high 25 / low 75 repeating -> from the second full period on: valid every 100 cycles, period=100, high_time=25, duty=256, overrun=0.
2. High 1 / low 999 -> period=1000, high_time=1, duty=1 (floor of 1.024). Also high 999 / low 1 -> duty=1022.
3. pwm_in held 1, timeout=500 -> valid every 500 cycles with duty=1024, period=0, level=1. pwm_in held 0 -> duty=0, high_time=0.
4. High 2 / low 2 with R=10 (period 4 < divide time 11) -> overrun=1, reported values period=4, duty=512. clr_ovr pulse -> overrun drops to 0 for one cycle, then is re-set by the next drop.
5. Assert reset 5 cycles after a divide launch -> no valid, all outputs 0, FSM IDLE. After release the first valid follows a discarded partial period.
6. Deassert en mid-HIGH, then reassert -> no valid while disabled, outputs hold, re-arm. The next report is the correct period and duty.
